// File: rtl/mips_mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mips_mc_control_fsm
//   Main control unit for the MIPS multi-cycle datapath. A Moore FSM steps
//   each instruction through fetch/decode/execute/memory/writeback and drives
//   all datapath selects and enables. Also holds the ALU decoder and the
//   PC-enable logic.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset, forces FETCH
//   opcode[5:0] in   instr[31:26]
//   funct[5:0]  in   instr[5:0]
//   zero        in   ALU zero flag
//   iord        out  memory address select (0 = PC, 1 = ALUOut)
//   mem_write   out  data memory write enable
//   ir_write    out  instruction register load
//   reg_dst     out  write-register select (0 = rt, 1 = rd)
//   mem_to_reg  out  write-data select (0 = ALUOut, 1 = MDR)
//   reg_write   out  register file write enable
//   alu_src_a   out  0 = PC, 1 = A
//   alu_src_b   out  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//   alu_control out  ALU operation
//   pc_src      out  00 = ALUResult, 01 = ALUOut, 10 = jump target
//   pc_en       out  PC load enable
//   state[3:0]  out  current state encoding (debug)
// ---------------------------------------------------------------------------
module mips_mc_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] w_alu_op;
    logic       w_pc_write;
    logic       w_branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = S_FETCH;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        w_alu_op   = 2'b00;
        w_pc_write = 1'b0;
        w_branch   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_next     = S_DECODE;
                ir_write   = 1'b1;
                w_pc_write = 1'b1;
                alu_src_b  = 2'b01;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_next = S_MEMWB;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_RTYPEEX: begin
                w_next    = S_RTYPEWB;
                alu_src_a = 1'b1;
                w_alu_op  = 2'b10;
            end
            S_RTYPEWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                w_alu_op  = 2'b01;
                w_branch  = 1'b1;
                pc_src    = 2'b01;
            end
            S_ADDIEX: begin
                w_next    = S_ADDIWB;
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JEX: begin
                w_pc_write = 1'b1;
                pc_src     = 2'b10;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // ALU decoder
    always_comb begin
        alu_control = 3'b010;
        case (w_alu_op)
            2'b01: alu_control = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: alu_control = 3'b010;
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
            default: alu_control = 3'b010;
        endcase
    end

    // zero feeds pc_en combinationally so a taken beq loads in BEQEX itself
    assign pc_en = w_pc_write | (w_branch & zero);
    assign state = r_state;

endmodule

// File: tb/tb_mips_mc_control_fsm.sv
module tb_mips_mc_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    int unsigned n_cmp;
    int unsigned n_err;

    mips_mc_control_fsm u_dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .pc_src      (pc_src),
        .pc_en       (pc_en),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle order:
    // {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
    //  alu_src_a, alu_src_b[1:0], alu_control[2:0], pc_src[1:0], pc_en}
    function automatic logic [14:0] pk(
        input logic iod, input logic mw, input logic irw, input logic rd,
        input logic m2r, input logic rw, input logic asa, input logic [1:0] asb,
        input logic [2:0] alu, input logic [1:0] pcs, input logic pce);
        return {iod, mw, irw, rd, m2r, rw, asa, asb, alu, pcs, pce};
    endfunction

    // Hand-derived expected output bundles per state
    localparam logic [14:0] E_FETCH   = 15'b0_0_1_0_0_0_0_01_010_00_1;
    localparam logic [14:0] E_DECODE  = 15'b0_0_0_0_0_0_0_11_010_00_0;
    localparam logic [14:0] E_MEMADR  = 15'b0_0_0_0_0_0_1_10_010_00_0;
    localparam logic [14:0] E_MEMRD   = 15'b1_0_0_0_0_0_0_00_010_00_0;
    localparam logic [14:0] E_MEMWB   = 15'b0_0_0_0_1_1_0_00_010_00_0;
    localparam logic [14:0] E_MEMWR   = 15'b1_1_0_0_0_0_0_00_010_00_0;
    localparam logic [14:0] E_RTYPEWB = 15'b0_0_0_1_0_1_0_00_010_00_0;
    localparam logic [14:0] E_ADDIEX  = 15'b0_0_0_0_0_0_1_10_010_00_0;
    localparam logic [14:0] E_ADDIWB  = 15'b0_0_0_0_0_1_0_00_010_00_0;
    localparam logic [14:0] E_JEX     = 15'b0_0_0_0_0_0_0_00_010_10_1;
    localparam logic [14:0] E_BEQ_T   = 15'b0_0_0_0_0_0_1_00_110_01_1;
    localparam logic [14:0] E_BEQ_NT  = 15'b0_0_0_0_0_0_1_00_110_01_0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check state and outputs of the current cycle, then advance one cycle
    task automatic cyc(input string tag, input logic [3:0] es, input logic [14:0] eo);
        #1;
        check({tag, ".state"}, {28'd0, state}, {28'd0, es});
        check({tag, ".outs"},
              {17'd0, pk(iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                         alu_src_a, alu_src_b, alu_control, pc_src, pc_en)},
              {17'd0, eo});
        @(negedge clk);
    endtask

    logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b000000};
    logic [2:0] ac_tab [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b010};

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        opcode = 6'b100011;
        funct  = 6'b000000;
        zero   = 1'b0;

        // Reset held: FETCH outputs
        cyc("rst", 4'd0, E_FETCH);
        cyc("rst2", 4'd0, E_FETCH);
        reset = 1'b0;

        // lw: 0,1,2,3,4,0
        cyc("lw0", 4'd0, E_FETCH);
        cyc("lw1", 4'd1, E_DECODE);
        cyc("lw2", 4'd2, E_MEMADR);
        cyc("lw3", 4'd3, E_MEMRD);
        cyc("lw4", 4'd4, E_MEMWB);

        // R-type slt
        opcode = 6'b000000;
        funct  = 6'b101010;
        cyc("rt0", 4'd0, E_FETCH);
        cyc("rt1", 4'd1, E_DECODE);
        cyc("rt6", 4'd6, 15'b0_0_0_0_0_0_1_00_111_00_0);
        cyc("rt7", 4'd7, E_RTYPEWB);

        // Remaining funct decodes, including an unlisted one
        for (int i = 0; i < 5; i++) begin
            funct = fn_tab[i];
            cyc("rfF", 4'd0, E_FETCH);
            cyc("rfD", 4'd1, E_DECODE);
            cyc("rfX", 4'd6, pk(0, 0, 0, 0, 0, 0, 1, 2'b00, ac_tab[i], 2'b00, 0));
            cyc("rfW", 4'd7, E_RTYPEWB);
        end

        // beq taken
        opcode = 6'b000100;
        funct  = 6'b111111;
        zero   = 1'b1;
        cyc("bqt0", 4'd0, E_FETCH);
        cyc("bqt1", 4'd1, E_DECODE);
        #1;
        check("bqt8.state", {28'd0, state}, 32'd8);
        check("bqt8.pc_en", {31'd0, pc_en}, 32'd1);
        // zero drives pc_en combinationally within the cycle
        zero = 1'b0;
        #1;
        check("bqt8.pc_en_comb", {31'd0, pc_en}, 32'd0);
        zero = 1'b1;
        cyc("bqt8", 4'd8, E_BEQ_T);

        // beq not taken
        zero = 1'b0;
        cyc("bqn0", 4'd0, E_FETCH);
        cyc("bqn1", 4'd1, E_DECODE);
        cyc("bqn8", 4'd8, E_BEQ_NT);

        // sw
        opcode = 6'b101011;
        cyc("sw0", 4'd0, E_FETCH);
        cyc("sw1", 4'd1, E_DECODE);
        cyc("sw2", 4'd2, E_MEMADR);
        cyc("sw5", 4'd5, E_MEMWR);

        // j
        opcode = 6'b000010;
        cyc("j0", 4'd0, E_FETCH);
        cyc("j1", 4'd1, E_DECODE);
        cyc("j11", 4'd11, E_JEX);

        // addi
        opcode = 6'b001000;
        cyc("ad0", 4'd0, E_FETCH);
        cyc("ad1", 4'd1, E_DECODE);
        cyc("ad9", 4'd9, E_ADDIEX);
        cyc("ad10", 4'd10, E_ADDIWB);

        // undefined opcode: DECODE straight back to FETCH
        opcode = 6'b111111;
        cyc("ud0", 4'd0, E_FETCH);
        cyc("ud1", 4'd1, E_DECODE);
        cyc("ud_back", 4'd0, E_FETCH);
        cyc("ud_next", 4'd1, E_DECODE);

        // Reset during MEMWR: asynchronous return to FETCH
        opcode = 6'b101011;
        cyc("rs0", 4'd0, E_FETCH);
        cyc("rs1", 4'd1, E_DECODE);
        cyc("rs2", 4'd2, E_MEMADR);
        #1;
        check("rs5.mem_write", {31'd0, mem_write}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rs_async.state", {28'd0, state}, 32'd0);
        check("rs_async.mem_write", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        cyc("rs_hold", 4'd0, E_FETCH);
        reset = 1'b0;
        opcode = 6'b100011;
        cyc("rs_f", 4'd0, E_FETCH);
        cyc("rs_d", 4'd1, E_DECODE);
        cyc("rs_m", 4'd2, E_MEMADR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
